// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
package if_stage_pkg;

  // Address of the first instruction fetched after reset.
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  // Inter-stage bus widths.
  localparam int unsigned FS_TO_DS_BUS_WD = 64;
  localparam int unsigned BR_BUS_WD       = 33;

  // Instruction SRAM port widths.
  localparam int unsigned INST_SRAM_AW  = 32;
  localparam int unsigned INST_SRAM_DW  = 32;
  localparam int unsigned INST_SRAM_WEW = 4;

  // IF -> ID payload: {pc, inst}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_bus_t;

  // ID -> IF redirect: {br_taken_cancel, br_target}.
  typedef struct packed {
    logic        taken_cancel;
    logic [31:0] target;
  } br_bus_t;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry holding register for SRAM read data while ID stalls.
module if_inst_buf
  import if_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fs_valid_i,
  input  logic                    ds_allow_in_i,
  input  logic                    br_taken_cancel_i,
  input  logic                    fetch_en_i,
  input  logic [INST_SRAM_DW-1:0] sram_rdata_i,
  output logic [INST_SRAM_DW-1:0] inst_c_o
);

  logic                    buf_valid_q, buf_valid_d;
  logic [INST_SRAM_DW-1:0] buf_inst_q,  buf_inst_d;
  logic                    capture_c;

  // Capture the live SRAM word on the first stalled cycle; its source request is gone next cycle.
  assign capture_c = fs_valid_i & ~buf_valid_q & ~ds_allow_in_i & ~br_taken_cancel_i;

  // Next-state: a new fetch always empties the buffer (covers the redirect flush).
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    if (fetch_en_i) begin
      buf_valid_d = 1'b0;
    end else if (capture_c) begin
      buf_valid_d = 1'b1;
      buf_inst_d  = sram_rdata_i;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_inst_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  // Held word takes priority over the (possibly stale) SRAM output.
  assign inst_c_o = buf_valid_q ? buf_inst_q : sram_rdata_i;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues SRAM reads, hands {pc, inst} to ID.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ds_allow_in,
  input  logic                     br_taken_cancel,
  input  logic [31:0]              br_target,
  output logic                     inst_sram_en,
  output logic [INST_SRAM_WEW-1:0] inst_sram_we,
  output logic [INST_SRAM_AW-1:0]  inst_sram_addr,
  output logic [INST_SRAM_DW-1:0]  inst_sram_wdata,
  input  logic [INST_SRAM_DW-1:0]  inst_sram_rdata,
  output logic                     fs_to_ds_valid,
  output logic [31:0]              fs_pc,
  output logic [31:0]              fs_inst
);

  logic                    fs_valid_q, fs_valid_d;
  logic [31:0]             fs_pc_q,    fs_pc_d;
  logic                    fs_ready_go_c;
  logic                    fs_allow_in_c;
  logic                    fetch_en_c;
  logic [31:0]             nextpc_c;
  logic [INST_SRAM_DW-1:0] fs_inst_c;
  br_bus_t                 br_bus_c;
  fs_to_ds_bus_t           fs_to_ds_bus_c;

  // Redirect from ID, gathered into its bus form.
  assign br_bus_c = '{taken_cancel: br_taken_cancel, target: br_target};

  // Handshake and next-PC selection; a redirect always frees IF.
  always_comb begin
    fs_ready_go_c = 1'b1;
    fs_allow_in_c = ~fs_valid_q | (fs_ready_go_c & ds_allow_in) | br_bus_c.taken_cancel;
    nextpc_c      = br_bus_c.taken_cancel ? br_bus_c.target : seq_pc(fs_pc_q);
    fetch_en_c    = ~reset & fs_allow_in_c;
  end

  // PC / valid next-state: advance only when a request goes out.
  always_comb begin
    fs_valid_d = fs_valid_q;
    fs_pc_d    = fs_pc_q;
    if (fetch_en_c) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc_c;
    end
  end

  // PC and valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q <= 1'b0;
      fs_pc_q    <= RESET_PC - 32'd4;
    end else begin
      fs_valid_q <= fs_valid_d;
      fs_pc_q    <= fs_pc_d;
    end
  end

  // Holding register for the fetched word.
  if_inst_buf u_inst_buf (
    .clk               (clk),
    .reset             (reset),
    .fs_valid_i        (fs_valid_q),
    .ds_allow_in_i     (ds_allow_in),
    .br_taken_cancel_i (br_bus_c.taken_cancel),
    .fetch_en_i        (fetch_en_c),
    .sram_rdata_i      (inst_sram_rdata),
    .inst_c_o          (fs_inst_c)
  );

  // Read-only SRAM port.
  assign inst_sram_en    = fetch_en_c;
  assign inst_sram_we    = '0;
  assign inst_sram_addr  = nextpc_c;
  assign inst_sram_wdata = '0;

  // IF -> ID payload; the wrong-path slot is killed in the redirect cycle.
  assign fs_to_ds_bus_c = '{pc: fs_pc_q, inst: fs_inst_c};
  assign fs_to_ds_valid = fs_valid_q & ~br_bus_c.taken_cancel;
  assign fs_pc          = fs_to_ds_bus_c.pc;
  assign fs_inst        = fs_to_ds_bus_c.inst;

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage against a PC-level reference model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        ds_allow_in;
  logic        br_taken_cancel;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allow_in     (ds_allow_in),
    .br_taken_cancel (br_taken_cancel),
    .br_target       (br_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_pc           (fs_pc),
    .fs_inst         (fs_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: every address holds a distinct pseudo-random word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h0bad_f00d;
  endfunction

  // Synchronous SRAM, 1-cycle latency; garbage when not requested.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : $urandom;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: which PC IF holds, and whether it holds one.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = RESET_PC - 32'd4;

  // PCs actually handed to ID.
  int xfer[logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int xfer_count(input logic [31:0] pc);
    return xfer.exists(pc) ? xfer[pc] : 0;
  endfunction

  // One clock cycle: drive, check mid-cycle against the model, advance the model at the edge.
  task automatic step(input logic rst_v, input logic ds_v, input logic br_v, input logic [31:0] tgt_v);
    logic        exp_en;
    logic [31:0] exp_np;
    reset           = rst_v;
    ds_allow_in     = ds_v;
    br_taken_cancel = br_v;
    br_target       = tgt_v;
    exp_en = !rst_v && (!m_valid || ds_v || br_v);
    exp_np = br_v ? tgt_v : m_pc + 32'd4;
    #3;
    if (chk_en) begin
      check_eq("sram_en", 32'(inst_sram_en), 32'(exp_en));
      check_eq("sram_addr", inst_sram_addr, exp_np);
      check_eq("sram_we", 32'(inst_sram_we), 32'h0);
      check_eq("sram_wdata", inst_sram_wdata, 32'h0);
      check_eq("fs_to_ds_valid", 32'(fs_to_ds_valid), 32'(m_valid && !br_v));
      check_eq("fs_pc", fs_pc, m_pc);
      if (m_valid) check_eq("fs_inst", fs_inst, mem_word(m_pc));
    end
    if (fs_to_ds_valid && ds_allow_in) xfer[fs_pc] = xfer_count(fs_pc) + 1;
    @(posedge clk);
    if (rst_v) begin
      m_valid = 1'b0;
      m_pc    = RESET_PC - 32'd4;
    end else if (exp_en) begin
      m_valid = 1'b1;
      m_pc    = exp_np;
    end
    #1;
  endtask

  task automatic run(input int n, input logic ds_v);
    for (int i = 0; i < n; i++) step(1'b0, ds_v, 1'b0, 32'h0);
  endtask

  initial begin
    logic        r_rst, r_ds, r_br;
    logic [31:0] r_tgt;
    reset = 1'b1; ds_allow_in = 1'b0; br_taken_cancel = 1'b0; br_target = '0;
    @(posedge clk); #1;

    // Reset for 3 cycles; state is only defined from the second one on.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk_en = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Streaming until IF holds 1c000020.
    run(9, 1'b1);
    check_eq("stream_pc", fs_pc, 32'h1c00_0020);

    // Mid-run reset, then restart from RESET_PC.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("restart_pc", fs_pc, 32'h1c00_0000);
    run(2, 1'b1);

    // Stall 3 cycles while IF holds 1c000008, then release.
    xfer.delete();
    check_eq("stall_pc", fs_pc, 32'h1c00_0008);
    run(3, 1'b0);
    run(2, 1'b1);
    check_eq("xfer_08_once", 32'(xfer_count(32'h1c00_0008)), 32'd1);
    check_eq("xfer_0c_once", 32'(xfer_count(32'h1c00_000c)), 32'd1);

    // Redirect with 1c000010 in IF.
    check_eq("br_pc", fs_pc, 32'h1c00_0010);
    step(1'b0, 1'b1, 1'b1, 32'h1c00_0100);
    check_eq("br_new_pc", fs_pc, 32'h1c00_0100);
    run(2, 1'b1);
    check_eq("xfer_10_never", 32'(xfer_count(32'h1c00_0010)), 32'd0);

    // Redirect while stalled with a full buffer.
    run(2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h1c00_0200);
    check_eq("stall_br_pc", fs_pc, 32'h1c00_0200);
    run(2, 1'b0);
    run(2, 1'b1);

    // Wrap-around of the sequential PC.
    step(1'b0, 1'b1, 1'b1, 32'hffff_fffc);
    run(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(63) == 0);
      r_ds  = ($urandom_range(3) != 0);
      r_br  = ($urandom_range(7) == 0);
      r_tgt = ($urandom_range(15) == 0) ? 32'hffff_fff8 : (32'h1c00_0000 | ($urandom & 32'h000f_fffc));
      step(r_rst, r_ds, r_br, r_tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
